// File: rtl/gpu_pkg.sv
// Shared defaults and scanout state encoding for the pixel scanout path.
package gpu_pkg;
    localparam int X_MAX_DEF      = 1920;
    localparam int Y_MAX_DEF      = 1080;
    localparam int PIX_W_DEF      = 24;
    localparam int ADDR_W_DEF     = 21;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;
endpackage

// File: rtl/scanout_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned pixels.
module scanout_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_scanout.sv
// Walks the framebuffer in raster order, credit-limits reads against the
// return FIFO, and tags each outgoing pixel with its coordinates.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in progress; waits for i_enable
// ST_FETCH | issuing reads while outstanding + buffered < FIFO_DEPTH
// ST_DRAIN | all reads issued; waiting for the last pixel to leave
module pixel_scanout
    import gpu_pkg::*;
#(
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MAX      = Y_MAX_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic [10:0]       o_pix_x,
    output logic [10:0]       o_pix_y,
    output logic              o_pix_sof,
    output logic              o_pix_eol,
    output logic              o_frame_done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_MAX * Y_MAX - 1);
    localparam logic [10:0]       X_LAST    = 11'(X_MAX - 1);
    localparam logic [10:0]       Y_LAST    = 11'(Y_MAX - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [CW-1:0]     r_outstanding;
    logic [10:0]       r_pix_x;
    logic [10:0]       r_pix_y;
    logic              r_frame_done;
    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic              w_credit;
    logic              w_rd_req;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pix;

    // Reads still in flight count against FIFO space so returns never overflow.
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < SW'(FIFO_DEPTH);
    assign w_accept   = w_rd_req && i_rd_ack;
    assign w_push     = i_rd_valid && (r_outstanding != '0);
    assign w_pop      = o_pix_valid && i_pix_ready;
    assign w_last_pix = w_pop && (r_pix_x == X_LAST) && (r_pix_y == Y_LAST);

    always_comb begin
        w_state_next = r_state;
        w_rd_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_rd_req = w_credit;
                if (w_rd_req && i_rd_ack && (r_rd_addr == LAST_ADDR)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_last_pix) w_state_next = i_enable ? ST_FETCH : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_rd_addr     <= '0;
            r_outstanding <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_last_pix;
            if (w_accept) begin
                r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
            end
            case ({w_accept, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_pop) begin
                if (r_pix_x == X_LAST) begin
                    r_pix_x <= '0;
                    r_pix_y <= (r_pix_y == Y_LAST) ? '0 : r_pix_y + 11'd1;
                end else begin
                    r_pix_x <= r_pix_x + 11'd1;
                end
            end
        end
    end

    scanout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (i_rd_data),
        .i_pop   (w_pop),
        .o_data  (o_pix_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_rd_req     = w_rd_req;
    assign o_rd_addr    = r_rd_addr;
    assign o_pix_valid  = !w_fifo_empty;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_sof    = o_pix_valid && (r_pix_x == '0) && (r_pix_y == '0);
    assign o_pix_eol    = o_pix_valid && (r_pix_x == X_LAST);
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_pixel_scanout.sv
// Self-checking bench for pixel_scanout on a 4x2 frame with a 4-deep return buffer.
module tb_pixel_scanout;
    localparam int XM   = 4;
    localparam int YM   = 2;
    localparam int PW   = 24;
    localparam int AW   = 21;
    localparam int FD   = 4;
    localparam int NPIX = XM * YM;

    logic          clk = 1'b0;
    logic          reset, enable, rd_ack, rd_valid, pix_ready;
    logic [PW-1:0] rd_data;
    logic          rd_req, pix_valid, pix_sof, pix_eol, frame_done;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] pix_data;
    logic [10:0]   pix_x, pix_y;

    always #5 clk = ~clk;

    pixel_scanout #(
        .X_MAX(XM), .Y_MAX(YM), .PIX_W(PW), .ADDR_W(AW), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_ack(rd_ack),
        .i_rd_valid(rd_valid), .i_rd_data(rd_data),
        .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_pix_data(pix_data),
        .o_pix_x(pix_x), .o_pix_y(pix_y), .o_pix_sof(pix_sof), .o_pix_eol(pix_eol),
        .o_frame_done(frame_done)
    );

    // Framebuffer contents: pixel at address a reads as {A0+a, 5A, ~a}.
    function automatic logic [PW-1:0] fb(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {8'hA0 + b, 8'h5A, ~b};
    endfunction

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Memory responder: returns accepted reads in order, one cycle later unless stalled.
    logic [AW-1:0] mq[$];
    bit            mem_stall = 0;
    initial begin
        bit            acc;
        logic [AW-1:0] ad;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            acc = rd_req && rd_ack && !reset;
            ad  = rd_addr;
            @(posedge clk);
            #1;
            if (acc) mq.push_back(ad);
            if (!mem_stall && mq.size() > 0) begin
                rd_valid = 1'b1;
                rd_data  = fb(int'(mq.pop_front()));
            end else begin
                rd_valid = 1'b0;
            end
        end
    end

    // Frame-level model: credits, buffered pixel count, next pixel index, frame phase.
    int  m_outst, m_fifo, m_idx, m_next_addr, m_mode;
    bit  m_done_pend, m_valid = 0, prev_stall;
    int  acc_log[$];
    logic [PW-1:0] pix_log[$];
    int  done_cnt, sof_cnt, eol_cnt, req_hi_cnt, pv_hi_cnt;
    bit  req_at_done;

    always @(negedge clk) begin
        bit acc, push, pop;
        if (m_valid) begin
            chk("pix_valid", pix_valid, m_fifo > 0);
            if (pix_valid) begin
                chk("pix_x", pix_x, m_idx % XM);
                chk("pix_y", pix_y, m_idx / XM);
                chk("pix_data", pix_data, fb(m_idx));
                chk("pix_sof", pix_sof, m_idx == 0);
                chk("pix_eol", pix_eol, (m_idx % XM) == XM - 1);
            end
            chk("frame_done", frame_done, m_done_pend);
            chk("rd_req", rd_req, (m_mode == 1) && (m_outst + m_fifo < FD));
            if (rd_req) chk("rd_addr", rd_addr, m_next_addr);
            if (prev_stall) chk("rd_req_hold", rd_req, 1);
        end
        if (!reset) begin
            if (frame_done) begin
                if (done_cnt == 0) req_at_done = rd_req;
                done_cnt++;
            end
            if (rd_req) req_hi_cnt++;
            if (pix_valid) pv_hi_cnt++;
        end
        if (reset) begin
            m_outst = 0; m_fifo = 0; m_idx = 0; m_next_addr = 0; m_mode = 0;
            m_done_pend = 0; prev_stall = 0; m_valid = 1;
        end else begin
            acc  = rd_req && rd_ack;
            push = rd_valid && (m_outst > 0);
            pop  = pix_valid && pix_ready;
            prev_stall = rd_req && !rd_ack;
            if (acc) begin
                acc_log.push_back(int'(rd_addr));
                m_outst++;
                if (m_next_addr == NPIX - 1) begin
                    m_next_addr = 0;
                    m_mode = 2;
                end else begin
                    m_next_addr++;
                end
            end
            if (push) begin
                m_outst--;
                m_fifo++;
            end
            m_done_pend = 0;
            if (pop) begin
                pix_log.push_back(pix_data);
                sof_cnt += int'(pix_sof);
                eol_cnt += int'(pix_eol);
                m_fifo--;
                if (m_idx == NPIX - 1) begin
                    m_idx = 0;
                    m_done_pend = 1;
                    if (m_mode == 2) m_mode = enable ? 1 : 0;
                end else begin
                    m_idx++;
                end
            end
            if (m_mode == 0 && enable) m_mode = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pix_log.delete();
        done_cnt = 0; sof_cnt = 0; eol_cnt = 0; req_hi_cnt = 0; pv_hi_cnt = 0;
        req_at_done = 0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            cyc(1);
            c++;
        end
        chk(name, done_cnt, target);
    endtask

    initial begin
        int c;
        reset = 1'b1; enable = 1'b0; rd_ack = 1'b0; pix_ready = 1'b0;
        clear_logs();
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        chk("rst_frame_done", frame_done, 0);

        // single frame, no backpressure
        clear_logs();
        rd_ack = 1'b1; pix_ready = 1'b1; enable = 1'b1;
        cyc(2);
        enable = 1'b0;
        wait_done(1, 100, "t1_done");
        cyc(3);
        chk("t1_acc_n", acc_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t1_addr", (i < acc_log.size()) ? acc_log[i] : -1, i);
        chk("t1_pix_n", pix_log.size(), 8);
        chk("t1_pix0", (pix_log.size() > 0) ? pix_log[0] : 0, 24'hA05AFF);
        chk("t1_pix5", (pix_log.size() > 5) ? pix_log[5] : 0, 24'hA55AFA);
        chk("t1_sof_n", sof_cnt, 1);
        chk("t1_eol_n", eol_cnt, 2);
        chk("t1_done_n", done_cnt, 1);
        req_hi_cnt = 0;
        cyc(10);
        chk("t1_idle_req", req_hi_cnt, 0);

        // downstream stalled: credit caps requests at FIFO depth
        clear_logs();
        pix_ready = 1'b0; enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        cyc(20);
        chk("t2_acc_n", acc_log.size(), FD);
        chk("t2_rd_req", rd_req, 0);
        chk("t2_pix_valid", pix_valid, 1);
        chk("t2_pix_data", pix_data, 24'hA05AFF);
        chk("t2_pix_x", pix_x, 0);
        pix_ready = 1'b1;
        wait_done(1, 100, "t2_done");
        chk("t2_pix_n", pix_log.size(), 8);
        chk("t2_pix7", (pix_log.size() > 7) ? pix_log[7] : 0, 24'hA75AF8);

        // read ack withheld for three cycles mid-frame
        clear_logs();
        enable = 1'b1;
        c = 0;
        while (acc_log.size() < 3 && c < 30) begin cyc(1); c++; end
        rd_ack = 1'b0; enable = 1'b0;
        cyc(3);
        chk("t3_addr_hold", rd_addr, 3);
        chk("t3_req_hold", rd_req, 1);
        chk("t3_acc_n", acc_log.size(), 3);
        rd_ack = 1'b1;
        wait_done(1, 100, "t3_done");
        chk("t3_pix_n", pix_log.size(), 8);
        chk("t3_pix3", (pix_log.size() > 3) ? pix_log[3] : 0, 24'hA35AFC);
        chk("t3_pix4", (pix_log.size() > 4) ? pix_log[4] : 0, 24'hA45AFB);

        // enable dropped mid-frame: frame still completes, then idle
        clear_logs();
        enable = 1'b1;
        c = 0;
        while (pix_log.size() < 3 && c < 30) begin cyc(1); c++; end
        enable = 1'b0;
        wait_done(1, 100, "t4_done");
        req_hi_cnt = 0;
        cyc(10);
        chk("t4_idle_req", req_hi_cnt, 0);
        chk("t4_pix_n", pix_log.size(), 8);
        chk("t4_done_n", done_cnt, 1);

        // reset with reads outstanding; late returns must be dropped
        clear_logs();
        rd_ack = 1'b0; mem_stall = 1; enable = 1'b1;
        cyc(3);
        rd_ack = 1'b1;
        cyc(4);
        rd_ack = 1'b0; enable = 1'b0;
        cyc(1);
        chk("t5_acc_n", acc_log.size(), 4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; mem_stall = 0;
        pv_hi_cnt = 0;
        cyc(8);
        chk("t5_stale_pv", pv_hi_cnt, 0);
        chk("t5_rd_addr", rd_addr, 0);
        clear_logs();
        rd_ack = 1'b1; pix_ready = 1'b1; enable = 1'b1;
        cyc(1);
        enable = 1'b0;
        wait_done(1, 100, "t5_done");
        chk("t5_first_addr", (acc_log.size() > 0) ? acc_log[0] : -1, 0);
        chk("t5_pix_n", pix_log.size(), 8);
        chk("t5_sof_n", sof_cnt, 1);

        // two back-to-back frames
        clear_logs();
        enable = 1'b1;
        wait_done(1, 100, "t6_done1");
        enable = 1'b0;
        wait_done(2, 100, "t6_done2");
        cyc(3);
        chk("t6_no_gap", req_at_done, 1);
        chk("t6_sof_n", sof_cnt, 2);
        chk("t6_pix_n", pix_log.size(), 16);
        chk("t6_acc_n", acc_log.size(), 16);
        chk("t6_addr8", (acc_log.size() > 8) ? acc_log[8] : -1, 0);
        chk("t6_pix8", (pix_log.size() > 8) ? pix_log[8] : 0, 24'hA05AFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
